// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port ids and width defaults
// for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_BOOST  = 1'b1
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int ARB_DATA_WIDTH = 16;
  localparam int ARB_ADDR_WIDTH = 12;
  localparam int WAIT_WIDTH     = 4;

  function automatic logic [WAIT_WIDTH-1:0] sat_inc(
    input logic [WAIT_WIDTH-1:0] v,
    input logic [WAIT_WIDTH-1:0] lim
  );
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_rd_tag.sv
// mem_arb_rd_tag: per-port read-valid flags, one cycle behind the
// grant, matching the RAM's registered read port.
module mem_arb_rd_tag
  import mem_arb_pkg::*;
#(
  parameter int PORTS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PORTS-1:0] gnt,
  input  logic [PORTS-1:0] write,
  output logic [PORTS-1:0] rd_valid
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= '0;
    end else begin
      rd_valid <= gnt & ~write;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU (A) / sprite engine (B) share one RAM port.
// Build option MEM_ARB_ROUND_ROBIN_EN swaps priority+boost for round robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic                  a_write,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  output logic                  a_gnt,
  output logic                  a_rd_valid,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_write,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  output logic                  b_gnt,
  output logic                  b_rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  logic       a_wins;
  logic [1:0] rd_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_B;
    end else if (a_gnt) begin
      last_grant <= PORT_A;
    end else if (b_gnt) begin
      last_grant <= PORT_B;
    end
  end

  always_comb a_wins = (last_grant == PORT_B);
`else
  localparam logic [WAIT_WIDTH-1:0] WAIT_LIM =
    WAIT_WIDTH'(MAX_WAIT);

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [WAIT_WIDTH-1:0] wait_b;
  logic [WAIT_WIDTH-1:0] wait_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_NORMAL;
      wait_b <= '0;
    end else begin
      state  <= state_nxt;
      wait_b <= wait_nxt;
    end
  end

  // boost is armed by the counter's next value, so B wins on cycle MAX_WAIT+1
  always_comb begin
    wait_nxt  = '0;
    state_nxt = state;
    if (b_req & ~b_gnt) begin
      wait_nxt = sat_inc(wait_b, WAIT_LIM);
    end
    unique case (state)
      ST_NORMAL: begin
        if (wait_nxt == WAIT_LIM) state_nxt = ST_BOOST;
      end
      ST_BOOST: begin
        if (b_gnt | ~b_req) state_nxt = ST_NORMAL;
      end
      default: state_nxt = ST_NORMAL;
    endcase
  end

  always_comb a_wins = (state == ST_NORMAL);
`endif

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      a_gnt = a_req & (a_wins | ~b_req);
      b_gnt = b_req & ~(a_req & a_wins);
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_write   = 1'b0;
    mem_wr_data = '0;
    unique case (1'b1)
      a_gnt: begin
        mem_addr    = a_addr;
        mem_write   = a_write;
        mem_wr_data = a_wr_data;
      end
      b_gnt: begin
        mem_addr    = b_addr;
        mem_write   = b_write;
        mem_wr_data = b_wr_data;
      end
      default: ;
    endcase
  end

  mem_arb_rd_tag #(
    .PORTS(2)
  ) u_rd_tag (
    .clock    (clock),
    .reset    (reset),
    .gnt      ({b_gnt, a_gnt}),
    .write    ({b_write, a_write}),
    .rd_valid (rd_valid)
  );

  assign a_rd_valid = rd_valid[PORT_A];
  assign b_rd_valid = rd_valid[PORT_B];
  assign rd_data    = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, mux, boost and read return
// against a small one-cycle RAM model.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_write, a_gnt, a_rd_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wr_data;
  logic          b_req, b_write, b_gnt, b_rd_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wr_data;
  logic [DW-1:0] rd_data, mem_wr_data, mem_rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_write;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;

  always #5 clock = ~clock;

  // 0x050 is cleared during reset so a leaked reset-time write shows up
  always @(posedge clock) begin
    if (mem_write) ram[mem_addr] <= mem_wr_data;
    else if (reset) ram[12'h050] <= 16'h0000;
    ram_q <= ram[mem_addr];
  end
  assign mem_rd_data = ram_q;

  mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_WAIT  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .a_req      (a_req),
    .a_addr     (a_addr),
    .a_write    (a_write),
    .a_wr_data  (a_wr_data),
    .a_gnt      (a_gnt),
    .a_rd_valid (a_rd_valid),
    .b_req      (b_req),
    .b_addr     (b_addr),
    .b_write    (b_write),
    .b_wr_data  (b_wr_data),
    .b_gnt      (b_gnt),
    .b_rd_valid (b_rd_valid),
    .rd_data    (rd_data),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  task automatic drive_a(input logic r, input logic w,
                         input logic [AW-1:0] ad,
                         input logic [DW-1:0] d);
    a_req = r; a_write = w; a_addr = ad; a_wr_data = d;
  endtask

  task automatic drive_b(input logic r, input logic w,
                         input logic [AW-1:0] ad,
                         input logic [DW-1:0] d);
    b_req = r; b_write = w; b_addr = ad; b_wr_data = d;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    drive_a(1'b1, 1'b1, 12'h050, 16'hDEAD);
    drive_b(1'b1, 1'b1, 12'h050, 16'hBEEF);
    #1;
    checks++;
    if (a_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_a_gnt got=%0b exp=0", a_gnt);
    end
    checks++;
    if (b_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_b_gnt got=%0b exp=0", b_gnt);
    end
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL rst_mem_write got=%0b exp=0", mem_write);
    end
    checks++;
    if (mem_addr !== 12'h000 || mem_wr_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mem_bus got=%h/%h exp=000/0000",
               mem_addr, mem_wr_data);
    end
    @(negedge clock);
    checks++;
    if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_valid got=%0b%0b exp=00",
               a_rd_valid, b_rd_valid);
    end
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 12'h010, 16'h0000);
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_mid_gnt got=%0b exp=1", a_gnt);
    end
    #2 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (a_rd_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid got=%0b exp=0", a_rd_valid);
    end
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    reset = 1'b0;
  endtask

  task automatic test_a_alone();
    @(negedge clock);
    drive_a(1'b1, 1'b1, 12'h010, 16'h1234);
    #1;
    checks++;
    if (a_gnt !== 1'b1 || mem_write !== 1'b1 ||
        mem_addr !== 12'h010 || mem_wr_data !== 16'h1234) begin
      errors++;
      $display("FAIL a_wr got gnt=%0b we=%0b %h/%h exp 1 1 010/1234",
               a_gnt, mem_write, mem_addr, mem_wr_data);
    end
    @(negedge clock);
    drive_a(1'b1, 1'b0, 12'h010, 16'h0000);
    #1;
    checks++;
    if (a_gnt !== 1'b1 || mem_write !== 1'b0 || a_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL a_rd_issue got gnt=%0b we=%0b v=%0b exp 1 0 0",
               a_gnt, mem_write, a_rd_valid);
    end
    @(negedge clock);
    drive_a(1'b1, 1'b0, 12'h050, 16'h0000);
    #1;
    checks++;
    if (a_rd_valid !== 1'b1 || rd_data !== 16'h1234 ||
        b_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL a_rd_data got v=%0b bv=%0b d=%h exp 1 0 1234",
               a_rd_valid, b_rd_valid, rd_data);
    end
    @(negedge clock);
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks++;
    if (a_rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_no_write got v=%0b d=%h exp 1 0000",
               a_rd_valid, rd_data);
    end
    @(negedge clock);
    checks++;
    if (a_rd_valid !== 1'b0) begin
      errors++; $display("FAIL a_idle_valid got=%0b exp=0", a_rd_valid);
    end
  endtask

  task automatic test_b_alone();
    drive_b(1'b1, 1'b0, 12'h010, 16'h0000);
    #1;
    checks++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
      errors++;
      $display("FAIL b_alone_gnt got a=%0b b=%0b exp 0 1", a_gnt, b_gnt);
    end
    @(negedge clock);
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks++;
    if (b_rd_valid !== 1'b1 || a_rd_valid !== 1'b0 ||
        rd_data !== 16'h1234) begin
      errors++;
      $display("FAIL b_rd got bv=%0b av=%0b d=%h exp 1 0 1234",
               b_rd_valid, a_rd_valid, rd_data);
    end
    @(negedge clock);
  endtask

`ifndef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_contention();
    logic exp_b;
    logic exp_av;
    exp_av = 1'b0;
    drive_a(1'b1, 1'b0, 12'h010, 16'h0000);
    drive_b(1'b1, 1'b1, 12'h020, 16'h00AA);
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_b = ((i % 5) == 4);
      checks++;
      if (a_gnt !== ~exp_b || b_gnt !== exp_b) begin
        errors++;
        $display("FAIL cont_gnt[%0d] got a=%0b b=%0b exp %0b %0b",
                 i, a_gnt, b_gnt, ~exp_b, exp_b);
      end
      checks++;
      if (a_rd_valid !== exp_av || b_rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL cont_valid[%0d] got a=%0b b=%0b exp %0b 0",
                 i, a_rd_valid, b_rd_valid, exp_av);
      end
      if (exp_b) begin
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 12'h020 ||
            mem_wr_data !== 16'h00AA) begin
          errors++;
          $display("FAIL cont_b_bus got we=%0b %h/%h exp 1 020/00aa",
                   mem_write, mem_addr, mem_wr_data);
        end
      end
      exp_av = ~exp_b;
      @(negedge clock);
    end
    drive_a(1'b1, 1'b0, 12'h020, 16'h0000);
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);
    @(negedge clock);
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks++;
    if (a_rd_valid !== 1'b1 || rd_data !== 16'h00AA) begin
      errors++;
      $display("FAIL cont_readback got v=%0b d=%h exp 1 00aa",
               a_rd_valid, rd_data);
    end
    @(negedge clock);
  endtask

  task automatic test_boost_exit();
    logic exp_b;
    drive_a(1'b1, 1'b0, 12'h010, 16'h0000);
    drive_b(1'b1, 1'b0, 12'h020, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
        errors++;
        $display("FAIL boost_pre[%0d] got a=%0b b=%0b exp 1 0",
                 i, a_gnt, b_gnt);
      end
      @(negedge clock);
    end
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL boost_drop got a=%0b b=%0b exp 1 0", a_gnt, b_gnt);
    end
    @(negedge clock);
    drive_b(1'b1, 1'b0, 12'h020, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_b = (i == 4);
      checks++;
      if (a_gnt !== ~exp_b || b_gnt !== exp_b) begin
        errors++;
        $display("FAIL boost_after[%0d] got a=%0b b=%0b exp %0b %0b",
                 i, a_gnt, b_gnt, ~exp_b, exp_b);
      end
      @(negedge clock);
    end
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks++;
    if (b_rd_valid !== 1'b1 || a_rd_valid !== 1'b0 ||
        rd_data !== 16'h00AA) begin
      errors++;
      $display("FAIL boost_b_rd got bv=%0b av=%0b d=%h exp 1 0 00aa",
               b_rd_valid, a_rd_valid, rd_data);
    end
    @(negedge clock);
  endtask

  task automatic test_same_addr();
    drive_a(1'b1, 1'b1, 12'h030, 16'h1111);
    drive_b(1'b1, 1'b1, 12'h030, 16'h2222);
    #1;
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_wr_data !== 16'h1111) begin
      errors++;
      $display("FAIL same_a got a=%0b b=%0b d=%h exp 1 0 1111",
               a_gnt, b_gnt, mem_wr_data);
    end
    @(negedge clock);
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks++;
    if (b_gnt !== 1'b1 || mem_addr !== 12'h030 ||
        mem_wr_data !== 16'h2222) begin
      errors++;
      $display("FAIL same_b got b=%0b %h/%h exp 1 030/2222",
               b_gnt, mem_addr, mem_wr_data);
    end
    @(negedge clock);
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);
    drive_a(1'b1, 1'b0, 12'h030, 16'h0000);
    @(negedge clock);
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks++;
    if (a_rd_valid !== 1'b1 || rd_data !== 16'h2222) begin
      errors++;
      $display("FAIL same_final got v=%0b d=%h exp 1 2222",
               a_rd_valid, rd_data);
    end
    @(negedge clock);
  endtask
`else
  task automatic test_round_robin();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 12'h010, 16'h0000);
    drive_b(1'b1, 1'b0, 12'h010, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (a_gnt !== ((i % 2) == 0) || b_gnt !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL rr_gnt[%0d] got a=%0b b=%0b", i, a_gnt, b_gnt);
      end
      @(negedge clock);
    end
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);
    @(negedge clock);
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b1, 12'h040 + 12'(i), 16'h4000 + 16'(i));
      #1;
      checks++;
      if (a_gnt !== 1'b1 || mem_write !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wr[%0d] got gnt=%0b we=%0b exp 1 1",
                 i, a_gnt, mem_write);
      end
      @(negedge clock);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_a(1'b1, 1'b0, 12'h040 + 12'(i), 16'h0000);
      else drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
      #1;
      if (i < 3) begin
        checks++;
        if (a_gnt !== 1'b1) begin
          errors++; $display("FAIL b2b_rd_gnt[%0d] got=%0b exp=1", i, a_gnt);
        end
      end
      if (i > 0) begin
        checks++;
        if (a_rd_valid !== 1'b1 || rd_data !== 16'h4000 + 16'(i - 1)) begin
          errors++;
          $display("FAIL b2b_rd[%0d] got v=%0b d=%h exp 1 %h",
                   i, a_rd_valid, rd_data, 16'h4000 + 16'(i - 1));
        end
      end
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);
    test_reset();
    test_a_alone();
    test_b_alone();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_contention();
    test_boost_exit();
    test_same_addr();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
